// File: rtl/vga_pkg.sv
// Shared types and defaults for the VGA framebuffer pixel fetch path.
package vga_pkg;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  typedef logic [23:0] pixel_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    DONE,
    DRAIN
  } fetch_state_e;
endpackage

// File: rtl/vga_pixel_fetch_if.sv
// Framebuffer read bus: single outstanding request, completed by mem_ack.
interface vga_pixel_fetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/vga_line_fifo.sv
// Synchronous pixel FIFO with flush; DEPTH must be a power of two so pointers wrap naturally.
module vga_line_fifo
  import vga_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  pixel_t        wdata_i,
  output pixel_t        rdata_o,
  output logic [AW:0]   count_o,
  output logic          empty_o,
  output logic          full_o
);
  pixel_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok;
  logic          pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (32'(count_q) == DEPTH);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Flush overrides both ports so a same-cycle push or pop is discarded.
  assign push_ok = push_i & ~full_o & ~flush_i;
  assign pop_ok  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/vga_pixel_fetch.sv
// Framebuffer-to-VGA pixel prefetcher: reads RGB888 words into a FIFO ahead of the timing stage.
// Optional macro VGA_FETCH_UNDERFLOW_CNT_EN adds a saturating underflow_cnt output.
module vga_pixel_fetch
  import vga_pkg::*;
#(
  parameter logic [31:0] FB_BASE    = 32'h0000_0000,
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_start,
  vga_pixel_fetch_if.master        mem,
  input  logic                     pix_rd,
  output pixel_t                   pix_data,
  output logic                     pix_valid,
  output logic                     underflow
`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]              underflow_cnt
`endif
);
  localparam int unsigned FCW         = $clog2(FIFO_DEPTH);
  localparam logic [31:0] TOTAL_WORDS = 32'(H_ACTIVE * V_ACTIVE);

  fetch_state_e state_q, state_d;
  logic         mem_req_q, mem_req_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  wcnt_q, wcnt_d;
  logic [31:0]  wcnt_inc;
  logic         push;
  logic         pop;
  logic         fifo_room;
  logic         fifo_full;
  logic         fifo_empty;
  logic [FCW:0] fifo_count;
  pixel_t       fifo_head;
  pixel_t       pix_data_q;
  logic         pix_valid_q;
  logic         underflow_q;
  logic         underflow_evt;
  logic         busy_bus;
  logic         unused_rdata_hi;

  assign unused_rdata_hi = ^{mem.mem_rdata[31:24], fifo_full};

  assign wcnt_inc  = wcnt_q + 32'd1;
  assign fifo_room = (32'(fifo_count) + 32'd1) <= FIFO_DEPTH;
  // A request still on the bus must run to its ack even across frame_start.
  assign busy_bus  = ((state_q == WAIT) || (state_q == DRAIN)) && !mem.mem_ack;

  vga_line_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (frame_start),
    .wdata_i (mem.mem_rdata[23:0]),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frame_start) begin
      state_d = busy_bus ? DRAIN : FETCH;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        FETCH:   if (fifo_room) state_d = WAIT;
        WAIT:    if (mem.mem_ack) state_d = (wcnt_inc == TOTAL_WORDS) ? DONE : FETCH;
        DONE:    state_d = DONE;
        DRAIN:   if (mem.mem_ack) state_d = FETCH;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req_d = mem_req_q;
    addr_d    = addr_q;
    wcnt_d    = wcnt_q;
    push      = 1'b0;
    if (frame_start) begin
      wcnt_d = '0;
      // Address is only rewound once the bus is free, keeping mem_addr stable while a request is open.
      if (!busy_bus) begin
        mem_req_d = 1'b0;
        addr_d    = FB_BASE;
      end
    end else begin
      unique case (state_q)
        FETCH: if (fifo_room) mem_req_d = 1'b1;
        WAIT: if (mem.mem_ack) begin
          mem_req_d = 1'b0;
          push      = 1'b1;
          addr_d    = addr_q + 32'd4;
          wcnt_d    = wcnt_inc;
        end
        DRAIN: if (mem.mem_ack) begin
          mem_req_d = 1'b0;
          addr_d    = FB_BASE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req_q <= 1'b0;
      addr_q    <= FB_BASE;
      wcnt_q    <= '0;
    end else begin
      mem_req_q <= mem_req_d;
      addr_q    <= addr_d;
      wcnt_q    <= wcnt_d;
    end
  end

  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = addr_q;

  assign pop           = pix_rd & ~fifo_empty & ~frame_start;
  assign underflow_evt = pix_rd & fifo_empty & ~frame_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else if (frame_start) begin
      underflow_q <= 1'b0;
      if (pix_rd) begin
        pix_data_q  <= '0;
        pix_valid_q <= 1'b0;
      end
    end else if (pix_rd) begin
      if (!fifo_empty) begin
        pix_data_q  <= fifo_head;
        pix_valid_q <= 1'b1;
      end else begin
        pix_data_q  <= '0;
        pix_valid_q <= 1'b0;
        underflow_q <= 1'b1;
      end
    end
  end

  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;
  assign underflow = underflow_q;

`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] ucnt_q;

  always_ff @(posedge clk) begin
    if (rst)                ucnt_q <= '0;
    else if (underflow_evt) ucnt_q <= sat_inc16(ucnt_q);
  end

  assign underflow_cnt = ucnt_q;
`else
  logic unused_uevt;
  assign unused_uevt = underflow_evt;
`endif
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed bench for vga_pixel_fetch: a full-size instance and a tiny 4x2 frame instance.
module tb_vga_pixel_fetch;
  import vga_pkg::*;

  localparam logic [31:0] BASE_A = 32'h1000_0000;
  localparam logic [31:0] BASE_B = 32'h0000_0000;

  logic   clk = 1'b0;
  logic   rst;
  logic   fs_a, fs_b, prd_a, prd_b;
  pixel_t pd_a, pd_b;
  logic   pv_a, pv_b, uf_a, uf_b;
`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
  logic [15:0] ucnt_a, ucnt_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] seen_a[$];
  logic [31:0] seen_b[$];

  always #5 clk = ~clk;

  vga_pixel_fetch_if mem_a ();
  vga_pixel_fetch_if mem_b ();

  vga_pixel_fetch #(.FB_BASE(BASE_A)) u_a (
    .clk(clk), .rst(rst), .frame_start(fs_a), .mem(mem_a), .pix_rd(prd_a),
    .pix_data(pd_a), .pix_valid(pv_a), .underflow(uf_a)
`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
    , .underflow_cnt(ucnt_a)
`endif
  );

  vga_pixel_fetch #(.FB_BASE(BASE_B), .H_ACTIVE(4), .V_ACTIVE(2)) u_b (
    .clk(clk), .rst(rst), .frame_start(fs_b), .mem(mem_b), .pix_rd(prd_b),
    .pix_data(pd_b), .pix_valid(pv_b), .underflow(uf_b)
`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
    , .underflow_cnt(ucnt_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Acks each request one cycle after it appears; data word = request ordinal (1-based).
  task automatic serve_a(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      mem_a.mem_ack = mem_a.mem_req;
      if (mem_a.mem_req) begin
        seen_a.push_back(mem_a.mem_addr);
        mem_a.mem_rdata = 32'(seen_a.size());
      end
      step();
    end
    mem_a.mem_ack = 1'b0;
  endtask

  task automatic serve_b(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      mem_b.mem_ack = mem_b.mem_req;
      if (mem_b.mem_req) begin
        seen_b.push_back(mem_b.mem_addr);
        mem_b.mem_rdata = 32'(seen_b.size());
      end
      step();
    end
    mem_b.mem_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fs_a = 1'b0; fs_b = 1'b0; prd_a = 1'b0; prd_b = 1'b0;
    mem_a.mem_ack = 1'b0; mem_a.mem_rdata = '0;
    mem_b.mem_ack = 1'b0; mem_b.mem_rdata = '0;
    repeat (3) step();
    chk("rst_req",   {31'd0, mem_a.mem_req}, 32'd0);
    chk("rst_addr",  mem_a.mem_addr, BASE_A);
    chk("rst_pdata", {8'd0, pd_a}, 32'd0);
    chk("rst_pvalid", {31'd0, pv_a}, 32'd0);
    chk("rst_uflow", {31'd0, uf_a}, 32'd0);
    rst = 1'b0;
    step();
    chk("idle_no_req", {31'd0, mem_a.mem_req}, 32'd0);

    // Prefetch until the 16-entry buffer is full.
    fs_a = 1'b1;
    step();
    fs_a = 1'b0;
    serve_a(60);
    chk("fill_req_count", 32'(seen_a.size()), 32'd16);
    for (int i = 0; i < seen_a.size(); i++)
      chk($sformatf("fill_addr%0d", i), seen_a[i], BASE_A + 32'(4 * i));
    chk("full_no_req", {31'd0, mem_a.mem_req}, 32'd0);

    // Drain 16 pixels back-to-back, then one read on empty.
    prd_a = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("pix%0d_data", i), {8'd0, pd_a}, 32'(i + 1));
      chk($sformatf("pix%0d_valid", i), {31'd0, pv_a}, 32'd1);
      chk($sformatf("pix%0d_uflow", i), {31'd0, uf_a}, 32'd0);
    end
    step();
    prd_a = 1'b0;
    chk("empty_pdata", {8'd0, pd_a}, 32'd0);
    chk("empty_pvalid", {31'd0, pv_a}, 32'd0);
    chk("empty_uflow", {31'd0, uf_a}, 32'd1);
    step();
    step();
    chk("uflow_sticky", {31'd0, uf_a}, 32'd1);
    chk("pvalid_hold", {31'd0, pv_a}, 32'd0);

    // frame_start while a request is open: held through drain, data discarded.
    chk("wait_req", {31'd0, mem_a.mem_req}, 32'd1);
    chk("wait_addr", mem_a.mem_addr, BASE_A + 32'd64);
    fs_a = 1'b1;
    step();
    fs_a = 1'b0;
    chk("fs_uflow_clr", {31'd0, uf_a}, 32'd0);
    chk("drain_hold1", {31'd0, mem_a.mem_req}, 32'd1);
    step();
    chk("drain_hold2", {31'd0, mem_a.mem_req}, 32'd1);
    step();
    mem_a.mem_ack = 1'b1;
    mem_a.mem_rdata = 32'h00AB_CDEF;
    step();
    mem_a.mem_ack = 1'b0;
    chk("drain_req_low", {31'd0, mem_a.mem_req}, 32'd0);
    step();
    chk("refetch_req", {31'd0, mem_a.mem_req}, 32'd1);
    chk("refetch_addr", mem_a.mem_addr, BASE_A);
    mem_a.mem_ack = 1'b1;
    mem_a.mem_rdata = 32'hFF12_3456;
    step();
    mem_a.mem_ack = 1'b0;
    prd_a = 1'b1;
    step();
    prd_a = 1'b0;
    chk("refetch_pdata", {8'd0, pd_a}, 32'h0012_3456);
    chk("refetch_pvalid", {31'd0, pv_a}, 32'd1);

    // frame_start with same-cycle pix_rd on a non-empty buffer: flush wins, no underflow.
    chk("pre_flush_req", {31'd0, mem_a.mem_req}, 32'd1);
    mem_a.mem_ack = 1'b1;
    mem_a.mem_rdata = 32'h0077_7777;
    step();
    mem_a.mem_ack = 1'b0;
    fs_a = 1'b1;
    prd_a = 1'b1;
    step();
    fs_a = 1'b0;
    chk("flush_rd_pvalid", {31'd0, pv_a}, 32'd0);
    chk("flush_rd_pdata", {8'd0, pd_a}, 32'd0);
    chk("flush_rd_uflow", {31'd0, uf_a}, 32'd0);
    step();
    prd_a = 1'b0;
    chk("post_flush_uflow", {31'd0, uf_a}, 32'd1);
    chk("post_flush_pvalid", {31'd0, pv_a}, 32'd0);

    // Tiny 4x2 frame: exactly 8 words then DONE.
    fs_b = 1'b1;
    step();
    fs_b = 1'b0;
    serve_b(40);
    chk("b_req_count", 32'(seen_b.size()), 32'd8);
    if (seen_b.size() > 0) begin
      chk("b_first_addr", seen_b[0], BASE_B);
      chk("b_last_addr", seen_b[seen_b.size() - 1], BASE_B + 32'd28);
    end
    chk("b_done_req", {31'd0, mem_b.mem_req}, 32'd0);
    repeat (5) step();
    chk("b_done_idle", {31'd0, mem_b.mem_req}, 32'd0);
    prd_b = 1'b1;
    step();
    prd_b = 1'b0;
    chk("b_pdata0", {8'd0, pd_b}, 32'd1);
    chk("b_pvalid0", {31'd0, pv_b}, 32'd1);

`ifdef VGA_FETCH_UNDERFLOW_CNT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ucnt_rst", {16'd0, ucnt_a}, 32'd0);
    prd_a = 1'b1;
    repeat (5) step();
    prd_a = 1'b0;
    chk("ucnt_5", {16'd0, ucnt_a}, 32'd5);
    fs_a = 1'b1;
    step();
    fs_a = 1'b0;
    chk("ucnt_keep_fs", {16'd0, ucnt_a}, 32'd5);
    prd_a = 1'b1;
    repeat (2) step();
    prd_a = 1'b0;
    chk("ucnt_7", {16'd0, ucnt_a}, 32'd7);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_pixel_fetch.md
VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 Parameter FB_BASE, default 32'h0000_0000, byte address of pixel (0,0) in framebuffer memory.
REQ-002 Parameter H_ACTIVE, default 640, active pixels per line.
REQ-003 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-004 Parameter FIFO_DEPTH, default 16, pixel buffer entries, power of two, minimum 4.
REQ-005 clk  in  1  sole clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 frame_start  in  1  one-cycle pulse from the VGA timing stage at vertical-blank start; restarts fetch at FB_BASE.
REQ-008 mem_req  out  1  framebuffer read request.
REQ-009 mem_addr  out  32  word-aligned read address.
REQ-010 mem_ack  in  1  read data valid; completes the current request.
REQ-011 mem_rdata  in  32  read word; bits [23:0] are RGB888, bits [31:24] ignored.
REQ-012 pix_rd  in  1  timing stage consumes one pixel this cycle (active area only).
REQ-013 pix_data  out  24  registered RGB888 pixel for the timing stage.
REQ-014 pix_valid  out  1  pix_data holds a real pixel from the buffer.
REQ-015 underflow  out  1  sticky flag: pixel requested while buffer empty; cleared by frame_start.

Function
REQ-016 FSM states IDLE, FETCH, WAIT, DONE, DRAIN; reset state IDLE.
REQ-017 IDLE: no requests; frame_start -> FETCH.
REQ-018 FETCH: if (fifo_count + 1) <= FIFO_DEPTH, assert mem_req with mem_addr = current address -> WAIT; otherwise stay in FETCH with mem_req low.
REQ-019 WAIT: mem_req and mem_addr held stable until mem_ack; at most one request outstanding.
REQ-020 On mem_ack in WAIT: write mem_rdata[23:0] to buffer, address += 4, word count += 1, mem_req low next cycle; -> DONE if word count reaches H_ACTIVE*V_ACTIVE, else FETCH.
REQ-021 DONE: no requests until frame_start -> FETCH.
REQ-022 frame_start in any state: buffer flushed, address = FB_BASE, word count = 0, underflow = 0, same cycle.
REQ-023 frame_start during WAIT -> DRAIN: mem_req held until mem_ack, data discarded, then -> FETCH at FB_BASE.
REQ-024 pix_rd with buffer non-empty: next cycle pix_data = buffer head, pix_valid = 1, head popped (1-cycle latency).
REQ-025 pix_rd with buffer empty: next cycle pix_data = 0, pix_valid = 0, underflow = 1; no pop.
REQ-026 No pix_rd: pix_data and pix_valid hold their values.
REQ-027 Same-cycle buffer write and pop both take effect; count unchanged.
REQ-028 Write into empty buffer with same-cycle pix_rd: no bypass; reported as underflow.
REQ-029 Buffer never overflows by construction (REQ-018); pointers wrap modulo FIFO_DEPTH.
REQ-030 frame_start and pix_rd in the same cycle: flush wins, pix_rd treated as underflow-free read of empty (pix_valid = 0, underflow stays 0).

Reset
REQ-031 rst: state IDLE, mem_req 0, mem_addr FB_BASE, pix_data 0, pix_valid 0, underflow 0, buffer empty, word count 0.
REQ-032 rst mid-request abandons the request; memory side must tolerate a dropped request.

Configuration
REQ-033 Macro VGA_FETCH_UNDERFLOW_CNT_EN defined: extra output underflow_cnt out 16, counts underflow events since reset, saturates at 16'hFFFF, not cleared by frame_start.
REQ-034 Macro undefined: no underflow_cnt port and no counter logic; all other behaviour identical.

Structure
REQ-035 Package vga_pkg: H_ACTIVE/V_ACTIVE defaults, FSM state enum, 24-bit pixel typedef.
REQ-036 Sub-module vga_line_fifo: synchronous FIFO with push, pop, flush, count, empty, full.

Verification
REQ-037 rst, frame_start, mem_ack one cycle after every mem_req -> addresses FB_BASE, +4, +8...; fetch stops with 16 entries buffered.
REQ-038 Buffer of pixels 0x000001..0x000010, pix_rd 16 consecutive cycles -> pix_data 0x000001..0x000010 each one cycle later, pix_valid 1, underflow 0.
REQ-039 pix_rd on empty buffer -> pix_data 0, pix_valid 0, underflow 1 until next frame_start.
REQ-040 frame_start while in WAIT, mem_ack 3 cycles later with 0xABCDEF -> data discarded, next mem_addr FB_BASE.
REQ-041 H_ACTIVE=4, V_ACTIVE=2 -> exactly 8 requests, last address FB_BASE+28, then DONE with mem_req 0.
REQ-042 With VGA_FETCH_UNDERFLOW_CNT_EN: 5 empty pix_rd, frame_start, 2 more -> underflow_cnt 7.
